// File: rtl/pll_sup_pkg.sv
// rtl/pll_sup_pkg.sv - shared state encoding and loss-counter constants for the PLL lock supervisor
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_sup_state_e;

  localparam int                    LOSS_CNT_W   = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

  function automatic logic [LOSS_CNT_W-1:0] loss_cnt_inc(input logic [LOSS_CNT_W-1:0] v);
    return (v == LOSS_CNT_MAX) ? v : v + LOSS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// rtl/pll_sup_sync.sv - STAGES-deep single-bit synchroniser with synchronous clear
module pll_sup_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock sequencer with timeout, retries and loss counting
// Optional RUN-state loss filter is enabled by defining PLL_SUP_LOSS_FILTER_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RETRY_MAX           = 3,
  parameter int CNT_W               = 20,
  parameter int LOSS_FILTER_CYCLES  = 4
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  output logic                  pll_rst,
  output logic                  sys_rst,
  output logic                  ready,
  output logic                  fault,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]            state_o
);

  localparam int RETRY_W = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);

  pll_sup_state_e     state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               lock_s;
  logic               loss_trig;
  logic               loss_evt;

  pll_sup_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk (refclk),
    .clr (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

`ifdef PLL_SUP_LOSS_FILTER_EN
  localparam int FILT_W = $clog2(LOSS_FILTER_CYCLES + 1);

  logic [FILT_W-1:0] filt_q, filt_d;

  // Only a run of LOSS_FILTER_CYCLES low samples in RUN counts as a real loss.
  assign loss_trig = !lock_s && (filt_q == FILT_W'(LOSS_FILTER_CYCLES - 1));

  always_comb begin
    filt_d = '0;
    if (state_q == ST_RUN && !lock_s && !loss_trig) begin
      filt_d = filt_q + FILT_W'(1);
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end
`else
  assign loss_trig = !lock_s;
`endif

  assign retry_inc = retry_q + RETRY_W'(1);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + CNT_W'(1);
    retry_d  = retry_q;
    loss_evt = 1'b0;
    case (state_q)
      ST_RESET_PLL: begin
        if (timer_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (lock_s) begin
          state_d = ST_STABLE;
          timer_d = '0;
        end else if (timer_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          timer_d = '0;
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_W'(RETRY_MAX)) ? ST_FAULT : ST_RESET_PLL;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = ST_RUN;
          timer_d = '0;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        timer_d = '0;
        if (loss_trig) begin
          state_d  = ST_RESET_PLL;
          loss_evt = 1'b1;
        end
      end
      ST_FAULT: begin
        timer_d = '0;
      end
      default: begin
        state_d = ST_RESET_PLL;
        timer_d = '0;
      end
    endcase
  end

  // Outputs decode state_d so they move on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q       <= ST_RESET_PLL;
      timer_q       <= '0;
      retry_q       <= '0;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      pll_rst <= (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
      sys_rst <= (state_d != ST_RUN);
      ready   <= (state_d == ST_RUN);
      fault   <= (state_d == ST_FAULT);
      if (loss_evt) begin
        lock_loss_cnt <= loss_cnt_inc(lock_loss_cnt);
      end
    end
  end

  assign state_o = state_q;

endmodule
